// File: rtl/wb_stage_pkg.sv
// Shared encodings and constants for the write-back stage.
// Pure definitions: no logic, no latency, no backpressure.
package wb_pkg;
    localparam logic [1:0] EXTR_WORD = 2'b00;
    localparam logic [1:0] EXTR_BYTE = 2'b01;
    localparam logic [1:0] EXTR_HALF = 2'b10;

    localparam logic [1:0] LH_NONE = 2'b00;
    localparam logic [1:0] LH_LO   = 2'b01;
    localparam logic [1:0] LH_HI   = 2'b10;

    localparam int unsigned SYSCALL_HALT = 10;
    localparam logic [4:0]  REG_RA       = 5'd31;
    localparam int unsigned LINK_OFFSET  = 8;
endpackage

// File: rtl/wb_stage_if.sv
// MEM/WB register outputs into write-back plus the regfile write port.
// Wires only: zero latency, no backpressure (the pipeline slot is always consumed).
interface wb_stage_if #(
    parameter int PC_BITS   = 32,
    parameter int IR_BITS   = 32,
    parameter int DATA_BITS = 32
) ();
    logic                 valid;
    logic [PC_BITS-1:0]   PC;
    logic [IR_BITS-1:0]   IR;
    logic                 Jal, MemToReg, RegWrite, ToLH, ExtrSigned, ld, Syscall;
    logic [1:0]           ExtrWord;
    logic [1:0]           LHToReg;
    logic [DATA_BITS-1:0] alu_out, alu_out2, mem_out, lo, hi;
    logic [5:0]           write;
    logic [DATA_BITS-1:0] v0, a0;

    logic                 reg_we;
    logic [4:0]           reg_waddr;
    logic [DATA_BITS-1:0] reg_wdata;

    modport master (
        output valid, PC, IR, Jal, MemToReg, RegWrite, ToLH, ExtrSigned, ld, Syscall,
        output ExtrWord, LHToReg, alu_out, alu_out2, mem_out, lo, hi, write, v0, a0,
        input  reg_we, reg_waddr, reg_wdata
    );

    modport slave (
        input  valid, PC, IR, Jal, MemToReg, RegWrite, ToLH, ExtrSigned, ld, Syscall,
        input  ExtrWord, LHToReg, alu_out, alu_out2, mem_out, lo, hi, write, v0, a0,
        output reg_we, reg_waddr, reg_wdata
    );
endinterface

// File: rtl/wb_stage_load_extract.sv
// Little-endian byte/halfword lane select with sign or zero extension of a loaded word.
// Combinational, zero latency, no backpressure.
module load_extract
    import wb_pkg::*;
#(
    parameter int DATA_BITS = 32
) (
    input  logic [DATA_BITS-1:0] mem_out_i,
    input  logic [1:0]           addr_i,
    input  logic [1:0]           extr_word_i,
    input  logic                 extr_signed_i,
    output logic [DATA_BITS-1:0] ext_o
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = mem_out_i[{addr_i, 3'b000} +: 8];
        // Halfword lane comes from addr[1] only; a misaligned addr[0] is ignored.
        half_v = mem_out_i[{addr_i[1], 4'b0000} +: 16];
        case (extr_word_i)
            EXTR_BYTE: ext_o = {{(DATA_BITS-8){extr_signed_i & byte_v[7]}}, byte_v};
            EXTR_HALF: ext_o = {{(DATA_BITS-16){extr_signed_i & half_v[15]}}, half_v};
            default:   ext_o = mem_out_i;
        endcase
    end
endmodule

// File: rtl/wb_stage.sv
// Write-back: regfile write mux (zero latency), HI/LO, syscall halt/display, perf counters.
// State updates take effect at the next clk edge; no backpressure, every valid slot retires.
module wb_stage
    import wb_pkg::*;
#(
    parameter int PC_BITS   = 32,
    parameter int IR_BITS   = 32,
    parameter int DATA_BITS = 32,
    parameter int CNT_BITS  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    wb_stage_if.slave            bus,
    output logic [DATA_BITS-1:0] hi_q,
    output logic [DATA_BITS-1:0] lo_q,
    output logic                 halt,
    output logic [DATA_BITS-1:0] disp_q,
    output logic                 disp_upd,
    output logic [CNT_BITS-1:0]  retire_cnt,
    output logic [CNT_BITS-1:0]  load_cnt
);
    logic                 halt_q, halt_d, disp_upd_q, disp_upd_d;
    logic [DATA_BITS-1:0] hi_d, lo_d, disp_d;
    logic [CNT_BITS-1:0]  retire_q, retire_d, load_q, load_d;
    logic                 live;
    logic [4:0]           waddr;
    logic [PC_BITS-1:0]   link_pc;
    logic [DATA_BITS-1:0] load_ext, wdata;
    logic                 unused_ok;

    assign live      = bus.valid & ~halt_q;
    assign unused_ok = ^{bus.IR, bus.alu_out2, bus.write[5]};

    load_extract #(.DATA_BITS(DATA_BITS)) u_extract (
        .mem_out_i     (bus.mem_out),
        .addr_i        (bus.alu_out[1:0]),
        .extr_word_i   (bus.ExtrWord),
        .extr_signed_i (bus.ExtrSigned),
        .ext_o         (load_ext)
    );

    assign link_pc = bus.PC + PC_BITS'(LINK_OFFSET);
    assign waddr   = bus.Jal ? REG_RA : bus.write[4:0];

    always_comb begin
        wdata = bus.alu_out;
        if (bus.Jal)                   wdata = DATA_BITS'(link_pc);
        else if (bus.LHToReg == LH_LO) wdata = lo_q;
        else if (bus.LHToReg == LH_HI) wdata = hi_q;
        else if (bus.MemToReg)         wdata = load_ext;
    end

    // Enable keys off the effective address so jal links to $31 even when write is 0;
    // rst gates it because the enable is combinational and halt_q is already cleared.
    assign bus.reg_we    = live & ~rst & bus.RegWrite & (waddr != 5'd0);
    assign bus.reg_waddr = waddr;
    assign bus.reg_wdata = wdata;

    always_comb begin
        hi_d       = hi_q;
        lo_d       = lo_q;
        halt_d     = halt_q;
        disp_d     = disp_q;
        disp_upd_d = 1'b0;
        retire_d   = retire_q;
        load_d     = load_q;
        if (live) begin
            retire_d = retire_q + CNT_BITS'(1);
            if (bus.ld) load_d = load_q + CNT_BITS'(1);
            if (bus.ToLH) begin
                hi_d = bus.hi;
                lo_d = bus.lo;
            end
            if (bus.Syscall) begin
                if (bus.v0 == DATA_BITS'(SYSCALL_HALT)) begin
                    halt_d = 1'b1;
                end else begin
                    disp_d     = bus.a0;
                    disp_upd_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q       <= '0;
            lo_q       <= '0;
            halt_q     <= 1'b0;
            disp_q     <= '0;
            disp_upd_q <= 1'b0;
            retire_q   <= '0;
            load_q     <= '0;
        end else begin
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            halt_q     <= halt_d;
            disp_q     <= disp_d;
            disp_upd_q <= disp_upd_d;
            retire_q   <= retire_d;
            load_q     <= load_d;
        end
    end

    assign halt       = halt_q;
    assign disp_upd   = disp_upd_q;
    assign retire_cnt = retire_q;
    assign load_cnt   = load_q;
endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: write-port scoreboard plus architectural state model.
module tb_wb_stage;
    localparam int DW = 32;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_stage_if #(.PC_BITS(32), .IR_BITS(32), .DATA_BITS(DW)) bus ();

    logic [DW-1:0] hi_q, lo_q, disp_q;
    logic          halt, disp_upd;
    logic [CW-1:0] retire_cnt, load_cnt;

    wb_stage #(.PC_BITS(32), .IR_BITS(32), .DATA_BITS(DW), .CNT_BITS(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .hi_q       (hi_q),
        .lo_q       (lo_q),
        .halt       (halt),
        .disp_q     (disp_q),
        .disp_upd   (disp_upd),
        .retire_cnt (retire_cnt),
        .load_cnt   (load_cnt)
    );

    typedef struct packed {
        logic          we;
        logic [4:0]    waddr;
        logic [DW-1:0] wdata;
    } wp_t;
    wp_t exp_q[$];

    logic [DW-1:0] m_hi, m_lo, m_disp;
    logic          m_halt, m_dupd;
    logic [CW-1:0] m_ret, m_ld;
    int            n_chk  = 0;
    int            n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [DW-1:0] model_ext(input logic [DW-1:0] mem, input logic [1:0] a,
                                                input logic [1:0] ew, input logic sg);
        logic [DW-1:0] sh;
        logic [7:0]    b;
        logic [15:0]   h;
        if (ew == 2'b01) begin
            sh = mem >> (8 * a);
            b  = sh[7:0];
            return (sg && b[7]) ? {24'hFFFFFF, b} : {24'h0, b};
        end else if (ew == 2'b10) begin
            sh = a[1] ? (mem >> 16) : mem;
            h  = sh[15:0];
            return (sg && h[15]) ? {16'hFFFF, h} : {16'h0, h};
        end
        return mem;
    endfunction

    task automatic idle();
        bus.valid = 0; bus.PC = '0; bus.IR = '0;
        bus.Jal = 0; bus.MemToReg = 0; bus.RegWrite = 0; bus.ToLH = 0;
        bus.ExtrSigned = 0; bus.ld = 0; bus.Syscall = 0;
        bus.ExtrWord = 2'b00; bus.LHToReg = 2'b00;
        bus.alu_out = '0; bus.alu_out2 = '0; bus.mem_out = '0; bus.lo = '0; bus.hi = '0;
        bus.write = 6'd0; bus.v0 = '0; bus.a0 = '0;
    endtask

    task automatic model_reset();
        m_hi = '0; m_lo = '0; m_disp = '0; m_halt = 0; m_dupd = 0; m_ret = '0; m_ld = '0;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".hi"},     hi_q,       m_hi);
        chk({tag, ".lo"},     lo_q,       m_lo);
        chk({tag, ".halt"},   halt,       m_halt);
        chk({tag, ".disp"},   disp_q,     m_disp);
        chk({tag, ".dupd"},   disp_upd,   m_dupd);
        chk({tag, ".retire"}, retire_cnt, m_ret);
        chk({tag, ".loads"},  load_cnt,   m_ld);
    endtask

    // Called shortly after a rising edge with inputs already driven.
    task automatic cycle(input string tag, input bit use_k, input logic [DW-1:0] k);
        wp_t  e;
        logic live;
        live    = bus.valid & ~m_halt;
        e.waddr = bus.Jal ? 5'd31 : bus.write[4:0];
        e.we    = live & bus.RegWrite & (e.waddr != 5'd0);
        if (bus.Jal)                  e.wdata = bus.PC + 32'd8;
        else if (bus.LHToReg == 2'b01) e.wdata = m_lo;
        else if (bus.LHToReg == 2'b10) e.wdata = m_hi;
        else if (bus.MemToReg)
            e.wdata = model_ext(bus.mem_out, bus.alu_out[1:0], bus.ExtrWord, bus.ExtrSigned);
        else                          e.wdata = bus.alu_out;
        exp_q.push_back(e);
        #1;
        e = exp_q.pop_front();
        chk({tag, ".we"},    bus.reg_we,    e.we);
        chk({tag, ".waddr"}, bus.reg_waddr, e.waddr);
        chk({tag, ".wdata"}, bus.reg_wdata, e.wdata);
        if (use_k) chk({tag, ".k"}, bus.reg_wdata, k);
        m_dupd = 0;
        if (live) begin
            m_ret++;
            if (bus.ld) m_ld++;
            if (bus.ToLH) begin m_hi = bus.hi; m_lo = bus.lo; end
            if (bus.Syscall) begin
                if (bus.v0 == 32'd10) m_halt = 1;
                else begin m_disp = bus.a0; m_dupd = 1; end
            end
        end
        @(posedge clk); #1;
        chk_state(tag);
    endtask

    logic [CW-1:0] frozen_ret;

    initial begin
        idle();
        model_reset();
        rst = 1;
        bus.valid = 1; bus.RegWrite = 1; bus.write = 6'd5;
        #3;
        chk("rst.we", bus.reg_we, 0);
        chk_state("rst");
        @(posedge clk); #1;
        rst = 0;
        idle();

        // Basic ALU write
        bus.valid = 1; bus.RegWrite = 1; bus.write = 6'd5; bus.alu_out = 32'h1234;
        cycle("alu", 1, 32'h1234);
        chk("alu.ret1", retire_cnt, 1);

        // Loads
        idle();
        bus.valid = 1; bus.RegWrite = 1; bus.MemToReg = 1; bus.ld = 1; bus.write = 6'd7;
        bus.mem_out = 32'h80FF7F01;
        bus.ExtrWord = 2'b01; bus.alu_out = 32'h3; bus.ExtrSigned = 1;
        cycle("lb", 1, 32'hFFFFFF80);
        bus.ExtrSigned = 0;
        cycle("lbu", 1, 32'h00000080);
        bus.ExtrWord = 2'b10; bus.alu_out = 32'h2; bus.ExtrSigned = 1;
        cycle("lh", 1, 32'hFFFF80FF);
        bus.alu_out = 32'h1;
        cycle("lh0", 1, 32'h00007F01);
        bus.ExtrWord = 2'b00;
        cycle("lw", 1, 32'h80FF7F01);
        chk("ld.cnt", load_cnt, 5);

        // HI/LO
        idle();
        bus.valid = 1; bus.ToLH = 1; bus.hi = 32'hA; bus.lo = 32'hB;
        cycle("mthl", 0, '0);
        chk("mthl.hi", hi_q, 32'hA);
        idle();
        bus.valid = 1; bus.RegWrite = 1; bus.write = 6'd8; bus.LHToReg = 2'b10;
        bus.hi = 32'h55; bus.lo = 32'h66;
        cycle("mfhi", 1, 32'hA);
        bus.LHToReg = 2'b01;
        cycle("mflo", 1, 32'hB);
        bus.LHToReg = 2'b10; bus.ToLH = 1; bus.hi = 32'hC;
        cycle("mfhi_old", 1, 32'hA);
        bus.ToLH = 0;
        cycle("mfhi_new", 1, 32'hC);

        // Jal and $0
        idle();
        bus.valid = 1; bus.RegWrite = 1; bus.Jal = 1; bus.PC = 32'h00400010; bus.write = 6'd0;
        cycle("jal", 1, 32'h00400018);
        bus.LHToReg = 2'b01;
        cycle("jal_lh", 1, 32'h00400018);
        bus.Jal = 0; bus.LHToReg = 2'b00; bus.write = 6'd32; bus.alu_out = 32'h77;
        cycle("r0", 0, '0);

        // Bubbles
        idle();
        bus.RegWrite = 1; bus.write = 6'd9; bus.ToLH = 1; bus.hi = 32'hDEAD;
        bus.Syscall = 1; bus.v0 = 32'd1; bus.a0 = 32'd7; bus.ld = 1;
        repeat (3) cycle("bubble", 0, '0);

        // Random traffic, never halting
        for (int i = 0; i < 40; i++) begin
            bus.valid = $urandom_range(0, 1); bus.PC = $urandom; bus.IR = $urandom;
            bus.Jal = ($urandom_range(0, 7) == 0); bus.MemToReg = $urandom_range(0, 1);
            bus.RegWrite = $urandom_range(0, 1); bus.ToLH = $urandom_range(0, 1);
            bus.ExtrSigned = $urandom_range(0, 1); bus.ld = $urandom_range(0, 1);
            bus.Syscall = ($urandom_range(0, 3) == 0);
            bus.ExtrWord = 2'($urandom_range(0, 3)); bus.LHToReg = 2'($urandom_range(0, 3));
            bus.alu_out = $urandom; bus.alu_out2 = $urandom; bus.mem_out = $urandom;
            bus.lo = $urandom; bus.hi = $urandom; bus.write = 6'($urandom_range(0, 63));
            bus.v0 = $urandom_range(0, 9); bus.a0 = $urandom;
            cycle("rand", 0, '0);
        end

        // Syscalls and halt
        idle();
        bus.valid = 1; bus.Syscall = 1; bus.v0 = 32'd1; bus.a0 = 32'd42;
        cycle("disp", 0, '0);
        chk("disp.val", disp_q, 32'd42);
        chk("disp.pulse", disp_upd, 1);
        idle();
        cycle("disp_off", 0, '0);
        chk("disp.pulse_off", disp_upd, 0);
        bus.valid = 1; bus.Syscall = 1; bus.v0 = 32'd10;
        cycle("halt", 0, '0);
        chk("halt.flag", halt, 1);
        frozen_ret = retire_cnt;
        idle();
        bus.valid = 1; bus.RegWrite = 1; bus.write = 6'd3; bus.alu_out = 32'h99;
        bus.ToLH = 1; bus.hi = 32'h123; bus.ld = 1; bus.Syscall = 1; bus.v0 = 32'd1; bus.a0 = 32'd99;
        cycle("halted", 0, '0);
        chk("halted.we", bus.reg_we, 0);
        chk("halted.ret", retire_cnt, frozen_ret);
        chk("halted.disp", disp_q, 32'd42);

        // Asynchronous reset between edges, with a live-looking slot on the bus
        bus.Syscall = 0; bus.ToLH = 0;
        #3 rst = 1;
        #1;
        model_reset();
        chk("arst.we", bus.reg_we, 0);
        chk_state("arst");
        idle();
        #1 rst = 0;
        @(posedge clk); #1;
        chk_state("arst_rel");

        // Counter wrap
        bus.valid = 1; bus.ld = 1;
        for (int i = 0; i < 255; i++) cycle("wrap_run", 0, '0);
        chk("wrap.pre_ret", retire_cnt, 8'hFF);
        chk("wrap.pre_ld", load_cnt, 8'hFF);
        cycle("wrap", 0, '0);
        chk("wrap.ret", retire_cnt, 0);
        chk("wrap.ld", load_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
